// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet receive types, constants and CRC-32 byte step
//
// Purpose : parser state encoding, framing constants, CRC-32 constants,
//           header record layout and the byte-parallel CRC-32 update used
//           by the RX parser and the TX FCS generator.
// Ports   : none (package).
package eth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DEST_ADDR,
        S_SRC_ADDR,
        S_TYPE,
        S_PAYLOAD,
        S_DROP
    } eth_state_e;

    localparam logic [7:0]  PREAMBLE      = 8'h55;
    localparam logic [7:0]  SFD           = 8'hD5;

    // CRC_POLY_REFL is CRC_POLY bit-reversed; the register shifts LSB first
    // because Ethernet transmits each byte LSB first.
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    // Raw register value after running data plus a correct FCS through it.
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int ETH_HDR_LEN = 14;
    localparam int ETH_FCS_LEN = 4;

    // First byte on the wire lands in the most significant byte of each field.
    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] eth_type;
    } eth_hdr_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mii_rx_parser_if.sv
// rtl/mii_rx_parser_if.sv - header record and payload stream bundle of the MII RX parser
//
// Purpose : groups the parser's outbound header and byte stream signals.
// Signals : dest_addr[47:0], src_addr[47:0], eth_type[15:0], hdr_valid,
//           m_axis_tdata[7:0], m_axis_tvalid, m_axis_tlast, m_axis_tuser.
// Modports: master - parser side (drives everything);
//           slave  - L3 dispatch side (samples everything).
interface mii_rx_parser_if;

    logic [47:0] dest_addr;
    logic [47:0] src_addr;
    logic [15:0] eth_type;
    logic        hdr_valid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;

    modport master (
        output dest_addr, src_addr, eth_type, hdr_valid,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        input dest_addr, src_addr, eth_type, hdr_valid,
        input m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

endinterface

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - byte-parallel reflected CRC-32 register
//
// Purpose : holds a running CRC-32; one byte folded in per enabled cycle.
// Ports   : mii_rx_clk - clock (rising edge)
//           rst        - synchronous active-high reset (loads CRC_INIT)
//           init       - reload CRC_INIT (wins over en)
//           en         - fold data into the register
//           data[7:0]  - byte to fold in
//           crc[31:0]  - raw register value (no final inversion)
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic        mii_rx_clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc32_byte(crc_q, data);
        end
    end

    always_ff @(posedge mii_rx_clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mii_rx_parser.sv
// rtl/mii_rx_parser.sv - MII receive deframer: header extraction, FCS-stripped payload stream
//
// Purpose : pairs MII nibbles into bytes, hunts preamble/SFD, captures the
//           14-byte Ethernet header, streams the payload with the FCS removed
//           and flags CRC, runt, overlength, odd-nibble and rx_er errors on
//           the final beat. No backpressure.
// Ports   : mii_rx_clk       - receive clock (rising edge)
//           rst              - synchronous active-high reset
//           mii_rx_data[3:0] - receive nibble, low nibble of each byte first
//           mii_rx_dv        - data valid
//           mii_rx_er        - receive error
//           out_if           - header record + payload byte stream (master)
module mii_rx_parser
    import eth_pkg::*;
#(
    parameter int C_MAX_PAYLOAD = 1500,
    parameter int C_MIN_PAYLOAD = 46
) (
    input  logic             mii_rx_clk,
    input  logic             rst,
    input  logic [3:0]       mii_rx_data,
    input  logic             mii_rx_dv,
    input  logic             mii_rx_er,
    mii_rx_parser_if.master  out_if
);

    localparam int CNT_W    = $clog2(C_MAX_PAYLOAD + 1);
    // One stage more than the FCS so the newest four bytes are always withheld.
    localparam int DL_DEPTH = ETH_FCS_LEN + 1;

    localparam logic [3:0]       DEST_LAST = 4'd5;
    localparam logic [3:0]       SRC_LAST  = 4'd11;
    localparam logic [3:0]       HDR_LAST  = 4'(ETH_HDR_LEN - 1);
    localparam logic [2:0]       DL_FULL   = 3'(DL_DEPTH);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(C_MAX_PAYLOAD - 1);
    localparam logic [CNT_W-1:0] PAY_SAT   = CNT_W'(C_MAX_PAYLOAD);
    localparam logic [CNT_W:0]   MIN_CNT   = (CNT_W + 1)'(C_MIN_PAYLOAD);

    eth_state_e                  state_q, state_d;
    logic                        dv_q, dv_d;
    logic                        nib_q, nib_d;
    logic [3:0]                  lo_q, lo_d;
    logic                        seen_q, seen_d;
    logic [3:0]                  hdr_cnt_q, hdr_cnt_d;
    logic [8*(ETH_HDR_LEN-1)-1:0] hdr_sr_q, hdr_sr_d;
    eth_hdr_t                    hdr_q, hdr_d;
    logic                        hdr_valid_q, hdr_valid_d;
    logic [DL_DEPTH-1:0][7:0]    dl_q, dl_d;
    logic [2:0]                  dl_cnt_q, dl_cnt_d;
    logic [CNT_W-1:0]            pay_cnt_q, pay_cnt_d;
    logic                        sticky_q, sticky_d;
    logic [7:0]                  tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;
    logic                        tuser_q, tuser_d;

    logic                        dv_rise;
    logic                        nib_cur;
    logic                        byte_done;
    logic [7:0]                  rx_byte;
    logic                        crc_init;
    logic                        crc_en;
    logic [31:0]                 crc;
    logic                        runt;
    logic                        in_frame;

    eth_crc32_d8 u_crc (
        .mii_rx_clk (mii_rx_clk),
        .rst        (rst),
        .init       (crc_init),
        .en         (crc_en),
        .data       (rx_byte),
        .crc        (crc)
    );

    // Nibble pairing: the dv rising edge forces the low-nibble phase.
    always_comb begin
        dv_d      = mii_rx_dv;
        dv_rise   = mii_rx_dv & ~dv_q;
        nib_cur   = dv_rise ? 1'b0 : nib_q;
        byte_done = mii_rx_dv & nib_cur;
        rx_byte   = {mii_rx_data, lo_q};
        nib_d     = nib_q;
        lo_d      = lo_q;
        if (mii_rx_dv) begin
            if (!nib_cur) begin
                lo_d  = mii_rx_data;
                nib_d = 1'b1;
            end else begin
                nib_d = 1'b0;
            end
        end
    end

    assign runt     = (({1'b0, pay_cnt_q} + (CNT_W + 1)'(1)) < MIN_CNT);
    assign in_frame = (state_q == S_DEST_ADDR) || (state_q == S_SRC_ADDR) ||
                      (state_q == S_TYPE)      || (state_q == S_PAYLOAD);

    always_comb begin
        state_d     = state_q;
        seen_d      = seen_q;
        hdr_cnt_d   = hdr_cnt_q;
        hdr_sr_d    = hdr_sr_q;
        hdr_d       = hdr_q;
        hdr_valid_d = 1'b0;
        dl_d        = dl_q;
        dl_cnt_d    = dl_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        sticky_d    = sticky_q;
        tdata_d     = 8'h00;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        crc_init    = 1'b0;
        crc_en      = 1'b0;

        if (in_frame && mii_rx_dv && mii_rx_er) begin
            sticky_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // dv already high without a seen rising edge means we woke
                // up mid-frame (e.g. after reset): discard the rest of it.
                if (mii_rx_dv) begin
                    state_d = dv_rise ? S_PREAMBLE : S_DROP;
                    seen_d  = 1'b0;
                end
            end

            S_PREAMBLE: begin
                if (!mii_rx_dv) begin
                    state_d = S_IDLE;
                end else if (byte_done) begin
                    if (rx_byte == PREAMBLE) begin
                        seen_d = 1'b1;
                    end else if (rx_byte == SFD && seen_q) begin
                        state_d   = S_DEST_ADDR;
                        crc_init  = 1'b1;
                        sticky_d  = 1'b0;
                        hdr_cnt_d = 4'd0;
                        dl_cnt_d  = 3'd0;
                        pay_cnt_d = '0;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end

            S_DEST_ADDR, S_SRC_ADDR, S_TYPE: begin
                if (!mii_rx_dv) begin
                    state_d = S_IDLE;
                end else if (byte_done) begin
                    crc_en    = 1'b1;
                    hdr_sr_d  = {hdr_sr_q[8*(ETH_HDR_LEN-2)-1:0], rx_byte};
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (state_q == S_DEST_ADDR && hdr_cnt_q == DEST_LAST) begin
                        state_d = S_SRC_ADDR;
                    end else if (state_q == S_SRC_ADDR && hdr_cnt_q == SRC_LAST) begin
                        state_d = S_TYPE;
                    end else if (state_q == S_TYPE && hdr_cnt_q == HDR_LAST) begin
                        state_d     = S_PAYLOAD;
                        hdr_d       = eth_hdr_t'({hdr_sr_q, rx_byte});
                        hdr_valid_d = 1'b1;
                    end
                end
            end

            S_PAYLOAD: begin
                if (!mii_rx_dv) begin
                    // End of frame: the oldest stage is the last payload byte
                    // unless the frame never filled the delay line.
                    state_d  = S_IDLE;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                    if (dl_cnt_q != DL_FULL) begin
                        tuser_d = 1'b1;
                    end else begin
                        tdata_d = dl_q[DL_DEPTH-1];
                        tuser_d = sticky_q | nib_q | (crc != CRC_RESIDUE) | runt;
                    end
                end else if (byte_done) begin
                    crc_en = 1'b1;
                    dl_d   = {dl_q[DL_DEPTH-2:0], rx_byte};
                    if (dl_cnt_q == DL_FULL) begin
                        tvalid_d = 1'b1;
                        tdata_d  = dl_q[DL_DEPTH-1];
                        // Only a frame longer than the maximum can shift out
                        // its last allowed byte while more bytes keep coming.
                        if (pay_cnt_q == PAY_LAST) begin
                            tlast_d = 1'b1;
                            tuser_d = 1'b1;
                            state_d = S_DROP;
                        end
                        if (pay_cnt_q != PAY_SAT) begin
                            pay_cnt_d = pay_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        dl_cnt_d = dl_cnt_q + 3'd1;
                    end
                end
            end

            S_DROP: begin
                if (!mii_rx_dv) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mii_rx_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dv_q        <= 1'b1;
            nib_q       <= 1'b0;
            lo_q        <= 4'h0;
            seen_q      <= 1'b0;
            hdr_cnt_q   <= 4'd0;
            hdr_sr_q    <= '0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            dl_q        <= '0;
            dl_cnt_q    <= 3'd0;
            pay_cnt_q   <= '0;
            sticky_q    <= 1'b0;
            tdata_q     <= 8'h00;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dv_q        <= dv_d;
            nib_q       <= nib_d;
            lo_q        <= lo_d;
            seen_q      <= seen_d;
            hdr_cnt_q   <= hdr_cnt_d;
            hdr_sr_q    <= hdr_sr_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            dl_q        <= dl_d;
            dl_cnt_q    <= dl_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            sticky_q    <= sticky_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
        end
    end

    assign out_if.dest_addr     = hdr_q.dest;
    assign out_if.src_addr      = hdr_q.src;
    assign out_if.eth_type      = hdr_q.eth_type;
    assign out_if.hdr_valid     = hdr_valid_q;
    assign out_if.m_axis_tdata  = tdata_q;
    assign out_if.m_axis_tvalid = tvalid_q;
    assign out_if.m_axis_tlast  = tlast_q;
    assign out_if.m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_mii_rx_parser.sv
// tb/tb_mii_rx_parser.sv - directed self-checking bench for mii_rx_parser
module tb_mii_rx_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mii_rx_data = 4'h0;
    logic       mii_rx_dv = 1'b0;
    logic       mii_rx_er = 1'b0;
    int         cyc = 0;

    int checks = 0;
    int failures = 0;

    logic [7:0]   rq[$];
    logic [9:0]   beats[$];
    int           beat_cycs[$];
    logic [111:0] hdrs[$];
    int           hdr_cycs[$];
    int           last_drv_cyc;
    int           hdr_drv_cyc;
    int           fall_cyc;

    mii_rx_parser_if pif ();

    mii_rx_parser #(
        .C_MAX_PAYLOAD (1500),
        .C_MIN_PAYLOAD (46)
    ) dut (
        .mii_rx_clk  (clk),
        .rst         (rst),
        .mii_rx_data (mii_rx_data),
        .mii_rx_dv   (mii_rx_dv),
        .mii_rx_er   (mii_rx_er),
        .out_if      (pif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pif.hdr_valid) begin
            hdrs.push_back({pif.dest_addr, pif.src_addr, pif.eth_type});
            hdr_cycs.push_back(cyc);
        end
        if (pif.m_axis_tvalid) begin
            beats.push_back({pif.m_axis_tuser, pif.m_axis_tlast, pif.m_axis_tdata});
            beat_cycs.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_nib(input logic [3:0] n, input logic er);
        mii_rx_dv    = 1'b1;
        mii_rx_data  = n;
        mii_rx_er    = er;
        last_drv_cyc = cyc;
        tick(1);
        mii_rx_er = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic er);
        send_nib(b[3:0], er);
        send_nib(b[7:4], 1'b0);
    endtask

    // Preamble, SFD, header, payload (i+seed), then FCS computed bit-serially.
    task automatic build_frame(input int seed, input int n);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        rq.delete();
        repeat (7) rq.push_back(8'h55);
        rq.push_back(8'hD5);
        for (int i = 1; i <= 6; i++) rq.push_back(8'(i));
        for (int i = 10; i <= 15; i++) rq.push_back(8'(i));
        rq.push_back(8'h08);
        rq.push_back(8'h00);
        for (int i = 0; i < n; i++) rq.push_back(8'(i + seed));
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < rq.size(); i++) begin
            b = rq[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[k];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        c = ~c;
        rq.push_back(c[7:0]);
        rq.push_back(c[15:8]);
        rq.push_back(c[23:16]);
        rq.push_back(c[31:24]);
    endtask

    task automatic send_raw(input int er_at, input int gap);
        for (int i = 0; i < rq.size(); i++) begin
            send_byte(rq[i], i == er_at);
            if (i == 21) hdr_drv_cyc = last_drv_cyc;
        end
        mii_rx_dv   = 1'b0;
        mii_rx_data = 4'h0;
        fall_cyc    = cyc;
        tick(gap);
    endtask

    task automatic clear_obs();
        beats.delete();
        beat_cycs.delete();
        hdrs.delete();
        hdr_cycs.delete();
    endtask

    task automatic check_stream(input string tag, input int base, input int n,
                                input int seed, input logic exp_user);
        int bad;
        int lasts;
        bad   = 0;
        lasts = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i < beats.size()) begin
                if (beats[base + i][7:0] != 8'(i + seed)) bad++;
                if (beats[base + i][8]) lasts++;
            end
        end
        check_eq({tag, "_data_errs"}, bad, 0);
        check_eq({tag, "_tlast_count"}, lasts, 1);
        if (base + n - 1 < beats.size()) begin
            check_eq({tag, "_last_tlast"}, beats[base + n - 1][8], 1);
            check_eq({tag, "_last_tuser"}, beats[base + n - 1][9], exp_user);
        end else begin
            check_eq({tag, "_beats_short"}, beats.size(), base + n);
        end
    endtask

    initial begin
        int lasts;

        tick(3);
        rst = 1'b0;
        tick(1);
        check_eq("rst_tvalid", pif.m_axis_tvalid, 0);
        check_eq("rst_tlast", pif.m_axis_tlast, 0);
        check_eq("rst_tuser", pif.m_axis_tuser, 0);
        check_eq("rst_hdr_valid", pif.hdr_valid, 0);
        check_eq("rst_dest", pif.dest_addr, 0);
        tick(2);

        // Good minimum frame
        clear_obs();
        build_frame(0, 46);
        send_raw(-1, 4);
        check_eq("good_hdr_count", hdrs.size(), 1);
        if (hdrs.size() > 0) begin
            check_eq("good_dest", hdrs[0][111:64], 48'h0102_0304_0506);
            check_eq("good_src", hdrs[0][63:16], 48'h0A0B_0C0D_0E0F);
            check_eq("good_type", hdrs[0][15:0], 16'h0800);
            check_eq("good_hdr_cyc", hdr_cycs[0], hdr_drv_cyc + 1);
        end
        check_eq("good_beats", beats.size(), 46);
        check_stream("good", 0, 46, 0, 1'b0);
        if (beats.size() == 46) check_eq("good_tlast_cyc", beat_cycs[45], fall_cyc + 1);

        // Corrupted FCS
        clear_obs();
        build_frame(0, 46);
        rq[rq.size() - 1] = rq[rq.size() - 1] ^ 8'h01;
        send_raw(-1, 4);
        check_eq("badfcs_beats", beats.size(), 46);
        check_stream("badfcs", 0, 46, 0, 1'b1);

        // Runt with valid FCS
        clear_obs();
        build_frame(3, 20);
        send_raw(-1, 4);
        check_eq("runt_beats", beats.size(), 20);
        check_stream("runt", 0, 20, 3, 1'b1);

        // dv drops after 3 destination bytes
        clear_obs();
        build_frame(0, 46);
        while (rq.size() > 11) void'(rq.pop_back());
        send_raw(-1, 4);
        check_eq("abort_hdr_count", hdrs.size(), 0);
        check_eq("abort_beats", beats.size(), 0);

        // Bad preamble byte
        clear_obs();
        build_frame(0, 46);
        rq[3] = 8'h57;
        send_raw(-1, 4);
        check_eq("badpre_hdr_count", hdrs.size(), 0);
        check_eq("badpre_beats", beats.size(), 0);

        // Short tail: only 2 bytes after the header
        clear_obs();
        build_frame(0, 2);
        repeat (4) void'(rq.pop_back());
        send_raw(-1, 4);
        check_eq("short_beats", beats.size(), 1);
        if (beats.size() > 0) check_eq("short_beat", beats[0], 10'h300);

        // rx_er mid-payload, then a back-to-back clean frame one cycle later
        clear_obs();
        build_frame(0, 46);
        send_raw(8 + 14 + 10, 1);
        build_frame(8'h40, 46);
        send_raw(-1, 4);
        check_eq("rxer_hdr_count", hdrs.size(), 2);
        check_eq("rxer_beats", beats.size(), 92);
        check_stream("rxer", 0, 46, 0, 1'b1);
        check_stream("b2b", 46, 46, 8'h40, 1'b0);

        // Overlength: 1501 payload bytes
        clear_obs();
        build_frame(7, 1501);
        send_raw(-1, 6);
        check_eq("over_beats", beats.size(), 1500);
        check_stream("over", 0, 1500, 7, 1'b1);

        // Reset mid-payload with dv held high, then a clean frame
        clear_obs();
        build_frame(0, 46);
        for (int i = 0; i < rq.size(); i++) begin
            if (i == 42) rst = 1'b1;
            send_byte(rq[i], 1'b0);
            rst = 1'b0;
        end
        mii_rx_dv = 1'b0;
        tick(4);
        lasts = 0;
        foreach (beats[i]) if (beats[i][8]) lasts++;
        check_eq("rstmid_tlast_count", lasts, 0);
        check_eq("rstmid_beats", beats.size(), 15);
        check_eq("rstmid_hdr_count", hdrs.size(), 1);
        clear_obs();
        build_frame(8'h20, 46);
        send_raw(-1, 4);
        check_eq("after_rst_beats", beats.size(), 46);
        check_stream("after_rst", 0, 46, 8'h20, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
